// File: rtl/data_mem_responder.sv
// Single-outstanding word memory responder: a request is accepted in IDLE, waits
// LATENCY cycles, and the memory access happens on the edge that enters RESP.
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | request latched, latency down-counter running
//   RESP  | response registered, held until rsp_ready
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, enter_resp;

  logic        lat_write;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_wstrb;

  logic        acc_write;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_wstrb;
  logic        acc_err;
  logic [AW-1:0] acc_idx;
  logic        mem_we;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wstrb <= req_wstrb;
    end
  end

  // With zero latency the access happens on the acceptance edge, so the live fields are used.
  assign acc_write = (LATENCY == 0) ? req_write : lat_write;
  assign acc_addr  = (LATENCY == 0) ? req_addr  : lat_addr;
  assign acc_wdata = (LATENCY == 0) ? req_wdata : lat_wdata;
  assign acc_wstrb = (LATENCY == 0) ? req_wstrb : lat_wstrb;

  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
  assign acc_idx = acc_addr[AW+1:2];
  assign mem_we  = enter_resp && acc_write && !acc_err && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else if (enter_resp) begin
      rsp_error <= acc_err;
      rsp_rdata <= (!acc_err && !acc_write) ? mem[acc_idx] : 32'd0;
    end else if (rsp_valid && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end
  end

  // Memory has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule
